// File: rtl/icache_fetch_pkg.sv
// icache_fetch_pkg: shared types and constants for the icache fetch controller.
// Exports the controller state enum, the line offset width and the fetch window size.
package icache_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        REQ1 = 3'd2,
        WAIT = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam int LINE_OFF_W  = 6;
    localparam int FETCH_BYTES = 16;

endpackage

// File: rtl/fetch_align_shifter.sv
// fetch_align_shifter: picks a FETCH_BYTES window out of two adjacent lines.
// Ports: i_lines {line1,line0}, i_off byte offset in line0, o_win window (byte 0 at i_off).
module fetch_align_shifter #(
    parameter int CACHELINE_BYTES = 64,
    parameter int FETCH_BYTES     = 16
) (
    input  logic [16*CACHELINE_BYTES-1:0]     i_lines,
    input  logic [$clog2(CACHELINE_BYTES)-1:0] i_off,
    output logic [8*FETCH_BYTES-1:0]          o_win
);

    logic [$clog2(CACHELINE_BYTES)+3:0] w_bit;

    assign w_bit = {1'b0, i_off, 3'b000};
    assign o_win = i_lines[w_bit +: 8*FETCH_BYTES];

endmodule

// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: core-side fetch master; one or two line requests per PC,
// window extraction, flush with in-flight response drop. Optional ICACHE_FETCH_LINEBUF_EN.
// Ports: i_fetch_* / o_fetch_rdy (PC in), o_inst_* / i_inst_rdy (window out),
// o_req/i_gnt/o_addr/i_rdata/i_rsp (icache channel), i_flush, clk, rst.
module icache_fetch_ctrl
    import icache_fetch_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int CACHELINE_BYTES = 64,
    parameter int FETCH_BYTES     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_fetch_vld,
    output logic                         o_fetch_rdy,
    input  logic [XLEN-1:0]              i_fetch_pc,
    input  logic                         i_flush,
    output logic                         o_inst_vld,
    input  logic                         i_inst_rdy,
    output logic [XLEN-1:0]              o_inst_pc,
    output logic [8*FETCH_BYTES-1:0]     o_inst_data,
    output logic                         o_req,
    input  logic                         i_gnt,
    output logic [XLEN-1:0]              o_addr,
    input  logic [8*CACHELINE_BYTES-1:0] i_rdata,
    input  logic                         i_rsp
);

    localparam int OFF_W = $clog2(CACHELINE_BYTES);
    localparam int LW    = 8*CACHELINE_BYTES;
    localparam logic [OFF_W-1:0] OFF_MAX =
        OFF_W'(CACHELINE_BYTES - FETCH_BYTES);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_line0;
    logic [XLEN-1:0] r_line1;
    logic            r_cross;
    logic [1:0]      r_rsp_cnt;
    logic [1:0]      r_outst;
    logic [1:0]      r_drop_cnt;
    logic [LW-1:0]   r_buf0;
    logic [LW-1:0]   r_buf1;

    logic            w_acc;
    logic            w_gnt;
    logic            w_cap;
    logic            w_cross;
    logic            w_hit;
    logic [OFF_W-1:0] w_off;
    logic [XLEN-1:0] w_line0;
    logic [1:0]      w_need;
    logic [1:0]      w_rsp_nxt;

    assign w_off   = i_fetch_pc[OFF_W-1:0];
    assign w_line0 = {i_fetch_pc[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign w_cross = w_off > OFF_MAX;

    assign o_fetch_rdy = !rst && (r_state == IDLE)
                         && (r_drop_cnt == 2'd0) && !i_flush;
    assign w_acc = i_fetch_vld && o_fetch_rdy;

    assign o_req = ((r_state == REQ0) || (r_state == REQ1)) && !i_flush;
    assign w_gnt = o_req && i_gnt;
    assign o_addr = (r_state == REQ1) ? r_line1 :
                    (r_state == REQ0) ? r_line0 : '0;

    // Responses in the flush cycle or while draining are never stored.
    assign w_cap = i_rsp && !i_flush && (r_drop_cnt == 2'd0)
                   && ((r_state == REQ1) || (r_state == WAIT));
    assign w_need    = r_cross ? 2'd2 : 2'd1;
    assign w_rsp_nxt = r_rsp_cnt + {1'b0, w_cap};

    assign o_inst_vld = (r_state == OUT);
    assign o_inst_pc  = r_pc;

`ifdef ICACHE_FETCH_LINEBUF_EN
    logic            r_lb_vld;
    logic            r_lb_sel;
    logic [XLEN-1:0] r_lb_tag;

    // The buffered line lives in r_buf0 or r_buf1 (r_lb_sel).
    assign w_hit = r_lb_vld && !w_cross && (w_line0 == r_lb_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lb_vld <= 1'b0;
            r_lb_tag <= '0;
        end else if (i_flush) begin
            r_lb_vld <= 1'b0;
        end else if (w_cap) begin
            r_lb_vld <= 1'b1;
            r_lb_tag <= r_rsp_cnt[0] ? r_line1 : r_line0;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (w_acc) w_state_nxt = w_hit ? OUT : REQ0;
                REQ0: if (w_gnt) w_state_nxt = r_cross ? REQ1 : WAIT;
                REQ1: if (w_gnt) w_state_nxt = WAIT;
                WAIT: if (w_rsp_nxt == w_need) w_state_nxt = OUT;
                OUT:  if (i_inst_rdy) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_line0    <= '0;
            r_line1    <= '0;
            r_cross    <= 1'b0;
            r_rsp_cnt  <= 2'd0;
            r_outst    <= 2'd0;
            r_drop_cnt <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_pc      <= i_fetch_pc;
                r_line0   <= w_line0;
                r_line1   <= w_line0 + XLEN'(CACHELINE_BYTES);
                r_cross   <= w_cross;
                r_rsp_cnt <= 2'd0;
            end else if (w_cap) begin
                r_rsp_cnt <= w_rsp_nxt;
            end
            // Outstanding grants; on flush all of them become drops.
            r_outst <= r_outst + {1'b0, w_gnt} - {1'b0, i_rsp};
            if (i_flush) begin
                r_drop_cnt <= r_outst - {1'b0, i_rsp};
            end else if (i_rsp && (r_drop_cnt != 2'd0)) begin
                r_drop_cnt <= r_drop_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
`ifdef ICACHE_FETCH_LINEBUF_EN
            r_lb_sel <= 1'b0;
`endif
        end else if (w_cap) begin
            if (r_rsp_cnt[0]) r_buf1 <= i_rdata;
            else              r_buf0 <= i_rdata;
`ifdef ICACHE_FETCH_LINEBUF_EN
            r_lb_sel <= r_rsp_cnt[0];
        end else if (w_acc && w_hit && r_lb_sel) begin
            // Move the buffered line into line0 slot for the shifter.
            r_buf0   <= r_buf1;
            r_lb_sel <= 1'b0;
`endif
        end
    end

    fetch_align_shifter #(
        .CACHELINE_BYTES (CACHELINE_BYTES),
        .FETCH_BYTES     (FETCH_BYTES)
    ) u_shift (
        .i_lines (({r_buf1, r_buf0})),
        .i_off   (r_pc[OFF_W-1:0]),
        .o_win   (o_inst_data)
    );

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// tb_icache_fetch_ctrl: directed bench.
// Line byte k at A is k ^ A[13:6].
`timescale 1ns/1ps
module tb_icache_fetch_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         fvld;
  logic         frdy;
  logic [63:0]  fpc;
  logic         flush;
  logic         ivld;
  logic         irdy;
  logic [63:0]  ipc;
  logic [127:0] idata;
  logic         req;
  logic         gnt;
  logic [63:0]  addr;
  logic [511:0] rdata;
  logic         rsp;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  icache_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_fetch_vld (fvld),
    .o_fetch_rdy (frdy),
    .i_fetch_pc  (fpc),
    .i_flush     (flush),
    .o_inst_vld  (ivld),
    .i_inst_rdy  (irdy),
    .o_inst_pc   (ipc),
    .o_inst_data (idata),
    .o_req       (req),
    .i_gnt       (gnt),
    .o_addr      (addr),
    .i_rdata     (rdata),
    .i_rsp       (rsp)
  );

  task automatic chk(
    input string        tag,
    input logic [511:0] obs,
    input logic [511:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: got %0h exp %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [511:0]
    line_of(input logic [63:0] a);
    logic [511:0] l;
    for (int k = 0; k < 64; k++)
      l[8*k +: 8] = 8'(k) ^ a[13:6];
    return l;
  endfunction

  function automatic logic [127:0]
    win_of(input logic [63:0] pc);
    logic [127:0] w;
    logic [63:0]  b;
    for (int i = 0; i < 16; i++) begin
      b = pc + 64'(i);
      w[8*i +: 8] = {2'b00, b[5:0]} ^ b[13:6];
    end
    return w;
  endfunction

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; fvld = 1'b1; fpc = 64'h1000;
    flush = 1'b0; irdy = 1'b0; gnt = 1'b0;
    rdata = '0; rsp = 1'b0;
    #1;
    chk("rst_req", req, 1'b0);
    chk("rst_vld", ivld, 1'b0);
    chk("rst_frdy", frdy, 1'b0);
    chk("rst_addr", addr, 64'h0);
    chk("rst_pc", ipc, 64'h0);
    chk("rst_data", idata, 128'h0);
    nxt(); rst = 1'b0; fvld = 1'b0;

    nxt(); fvld = 1'b1; fpc = 64'h1000; #1;
    chk("t1_frdy", frdy, 1'b1);
    nxt(); fvld = 1'b0; gnt = 1'b1; #1;
    chk("t1_req", req, 1'b1);
    chk("t1_addr", addr, 64'h1000);
    nxt(); gnt = 1'b0; rsp = 1'b1;
    rdata = line_of(64'h1000); #1;
    chk("t1_vld_early", ivld, 1'b0);
    chk("t1_req_off", req, 1'b0);
    nxt(); rsp = 1'b0; irdy = 1'b1; #1;
    chk("t1_vld", ivld, 1'b1);
    chk("t1_pc", ipc, 64'h1000);
    chk("t1_data", idata, win_of(64'h1000));
    nxt(); irdy = 1'b0; #1;
    chk("t1_idle_vld", ivld, 1'b0);
    chk("t1_idle_frdy", frdy, 1'b1);

    nxt(); fvld = 1'b1; fpc = 64'h1038;
    nxt(); fvld = 1'b0; gnt = 1'b1; #1;
    chk("t2_addr0", addr, 64'h1000);
    nxt(); rsp = 1'b1;
    rdata = line_of(64'h1000); #1;
    chk("t2_req1", req, 1'b1);
    chk("t2_addr1", addr, 64'h1040);
    nxt(); gnt = 1'b0;
    rdata = line_of(64'h1040); #1;
    chk("t2_req_off", req, 1'b0);
    chk("t2_vld_early", ivld, 1'b0);
    nxt(); rsp = 1'b0; irdy = 1'b1; #1;
    chk("t2_vld", ivld, 1'b1);
    chk("t2_data", idata, win_of(64'h1038));
    nxt(); irdy = 1'b0;

    nxt(); fvld = 1'b1; fpc = 64'h1000;
    for (int i = 0; i < 3; i++) begin
      nxt(); fvld = 1'b0; #1;
      chk("t3_req_hold", req, 1'b1);
      chk("t3_addr_hold", addr, 64'h1000);
    end
    nxt(); gnt = 1'b1;
    nxt(); gnt = 1'b0; rsp = 1'b1;
    rdata = line_of(64'h1000);
    for (int i = 0; i < 4; i++) begin
      nxt(); rsp = 1'b0; #1;
      chk("t5_vld_hold", ivld, 1'b1);
      chk("t5_pc_hold", ipc, 64'h1000);
      chk("t5_data_hold", idata,
          win_of(64'h1000));
      chk("t5_frdy_low", frdy, 1'b0);
    end
    nxt(); irdy = 1'b1;
    nxt(); irdy = 1'b0; #1;
    chk("t5_vld_off", ivld, 1'b0);
    chk("t5_frdy", frdy, 1'b1);

    nxt(); fvld = 1'b1; fpc = 64'h1038;
    nxt(); fvld = 1'b0; gnt = 1'b1;
    nxt(); gnt = 1'b0; flush = 1'b1; #1;
    chk("t4_req_gated", req, 1'b0);
    chk("t4_frdy_flush", frdy, 1'b0);
    nxt(); flush = 1'b0; fvld = 1'b1;
    fpc = 64'h2000; #1;
    chk("t4_frdy_drop", frdy, 1'b0);
    chk("t4_req_idle", req, 1'b0);
    nxt(); rsp = 1'b1;
    rdata = line_of(64'h1000); #1;
    chk("t4_frdy_drop2", frdy, 1'b0);
    nxt(); rsp = 1'b0; #1;
    chk("t4_frdy_free", frdy, 1'b1);
    nxt(); fvld = 1'b0; gnt = 1'b1; #1;
    chk("t4_addr", addr, 64'h2000);
    nxt(); gnt = 1'b0; rsp = 1'b1;
    rdata = line_of(64'h2000);
    nxt(); rsp = 1'b0; irdy = 1'b1; #1;
    chk("t4_vld", ivld, 1'b1);
    chk("t4_pc", ipc, 64'h2000);
    chk("t4_data", idata, win_of(64'h2000));
    nxt(); irdy = 1'b0;

    nxt(); fvld = 1'b1; fpc = 64'h1000;
    nxt(); fvld = 1'b0; gnt = 1'b1;
    nxt(); gnt = 1'b0; flush = 1'b1;
    rsp = 1'b1;
    rdata = line_of(64'h1000);
    nxt(); flush = 1'b0; rsp = 1'b0; #1;
    chk("t6_frdy", frdy, 1'b1);
    chk("t6_vld", ivld, 1'b0);

    nxt(); fvld = 1'b1;
    fpc = 64'hFFFF_FFFF_FFFF_FFF8;
    nxt(); fvld = 1'b0; gnt = 1'b1; #1;
    chk("tw_addr0", addr,
        64'hFFFF_FFFF_FFFF_FFC0);
    nxt(); rsp = 1'b1;
    rdata = line_of(64'hFFFF_FFFF_FFFF_FFC0);
    #1;
    chk("tw_addr1", addr, 64'h0);
    nxt(); gnt = 1'b0; rdata = line_of(64'h0);
    nxt(); rsp = 1'b0; irdy = 1'b1; #1;
    chk("tw_vld", ivld, 1'b1);
    chk("tw_data", idata,
        win_of(64'hFFFF_FFFF_FFFF_FFF8));
    nxt(); irdy = 1'b0;

    nxt(); fvld = 1'b1; fpc = 64'h1000;
    nxt(); fvld = 1'b0; gnt = 1'b1;
    nxt(); gnt = 1'b0; rsp = 1'b1;
    rdata = line_of(64'h1000);
    nxt(); rsp = 1'b0; irdy = 1'b1;
    nxt(); irdy = 1'b0; fvld = 1'b1;
    fpc = 64'h1010;
    nxt(); fvld = 1'b0; rdata = '0; #1;
`ifdef ICACHE_FETCH_LINEBUF_EN
    chk("lb_no_req", req, 1'b0);
    chk("lb_vld", ivld, 1'b1);
    chk("lb_data", idata, win_of(64'h1010));
`else
    chk("nolb_req", req, 1'b1);
    chk("nolb_addr", addr, 64'h1000);
    gnt = 1'b1;
    nxt(); gnt = 1'b0; rsp = 1'b1;
    rdata = line_of(64'h1000);
    nxt(); rsp = 1'b0; #1;
    chk("nolb_vld", ivld, 1'b1);
    chk("nolb_data", idata,
        win_of(64'h1010));
`endif
    flush = 1'b1; irdy = 1'b1;
    nxt(); flush = 1'b0; irdy = 1'b0; #1;
    chk("fo_vld", ivld, 1'b0);
    chk("fo_frdy", frdy, 1'b1);

    nxt();
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
